// File: rtl/csa_sub_serial.sv
// csa_sub_serial
//   Iterative two's-complement subtractor: diff = op1 - op2 - bin (mod 2^WIDTH),
//   two bits per clock using a 2-bit carry-select slice on op1 + ~op2.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while busy=0 (IDLE or DONE)
//   op1    minuend, captured on accepted start
//   op2    subtrahend, captured on accepted start
//   bin    borrow in, captured on accepted start
//   busy   high while slices are being processed
//   done   one-cycle pulse when diff/bout/ovf have been updated
//   diff   result, held between operations
//   bout   borrow out (1 iff op1 < op2 + bin, unsigned)
//   ovf    signed overflow of the subtraction
module csa_sub_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("csa_sub_serial: WIDTH must be even and >= 2");
  end

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  // op1_sh doubles as the partial-result register: each RUN cycle it shifts
  // right by two, consuming the low slice and inserting the slice sum at the
  // top, so after WIDTH/2 cycles it holds the full difference. This keeps the
  // slice operand a fixed bit position (no WIDTH-dependent select mux).
  logic [WIDTH-1:0] op1_sh;
  logic [WIDTH-1:0] op2_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             op1_msb;
  logic             op2_msb;

  logic             accept;
  logic [2:0]       sum0, sum1, sel;
  logic [WIDTH-1:0] sh_nxt;

  // Two-bit carry-select slice: both candidate sums are built in parallel,
  // the stored carry only drives the final mux.
  always_comb begin
    sum0   = {1'b0, op1_sh[1:0]} + {1'b0, ~op2_sh[1:0]};
    sum1   = {1'b0, op1_sh[1:0]} + {1'b0, ~op2_sh[1:0]} + 3'd1;
    sel    = carry ? sum1 : sum0;
    sh_nxt = (op1_sh >> 2) | (WIDTH'(sel[1:0]) << (WIDTH - 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_sh  <= '0;
      op2_sh  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      op1_msb <= 1'b0;
      op2_msb <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      op1_sh  <= op1;
      op2_sh  <= op2;
      cnt     <= '0;
      carry   <= ~bin;
      op1_msb <= op1[WIDTH-1];
      op2_msb <= op2[WIDTH-1];
    end else if (state == RUN) begin
      op1_sh <= sh_nxt;
      op2_sh <= op2_sh >> 2;
      cnt    <= cnt + CW'(1);
      carry  <= sel[2];
      // Results are registered on the last slice edge so they appear
      // together with done in the DONE cycle.
      if (cnt == LAST) begin
        diff <= sh_nxt;
        bout <= ~sel[2];
        ovf  <= (op1_msb ^ op2_msb) & (sel[1] ^ op1_msb);
      end
    end
  end

endmodule
